// File: rtl/fu_mult_pipe.sv
// rtl/fu_mult_pipe.sv - pipelined integer multiply functional unit with CDB back-pressure
//
// Purpose:
//    Multiplies two WIDTH_P-bit operands in one of four modes and delivers the
//    selected WIDTH_P-bit half through a STAGES_P-deep pipe. The last entry
//    drives the ROB and register/CDB writeback structs. The CDB arbiter
//    back-pressures the unit through yumi_i, and a mispredict empties it in
//    one cycle.
//
// Ports:
//    clk_i         clock
//    reset_i       synchronous active-high reset
//    exe_v_i       issue valid
//    ready_o       unit can accept an issue this cycle (combinational in yumi_i)
//    mode_i        00 MUL low, 01 MULH s*s, 10 MULHU u*u, 11 MULHSU s*u
//    operand1_i    multiplicand
//    operand2_i    multiplier
//    rob_dest_i    ROB tag of the issue
//    reg_dest_i    physical destination tag of the issue
//    mult_rob_o    rob_wb_t  = {rob_dest}
//    mult_reg_o    reg_wb_t  = {w_v, cdb}, cdb = {valid, dest, result, flags}
//    yumi_i        CDB arbiter consumed the current output
//    mispredict_i  flush every in-flight op
//    inflight_o    number of valid pipeline entries

module fu_mult_pipe #(
   parameter int WORD_SIZE_P  = 32,
   parameter int WIDTH_P      = WORD_SIZE_P,
   parameter int STAGES_P     = 2,
   parameter int ROB_ENTRY    = 32,
   parameter int NUM_PHYS_REG = 64,
   parameter int ROB_IDX_W    = $clog2(ROB_ENTRY),
   parameter int REG_IDX_W    = $clog2(NUM_PHYS_REG),
   parameter int FLAGS_W      = 2,
   localparam int CDB_WIDTH    = 1 + REG_IDX_W + WIDTH_P + FLAGS_W,
   localparam int ROB_WB_WIDTH = ROB_IDX_W,
   localparam int REG_WB_WIDTH = 1 + CDB_WIDTH,
   localparam int CNT_W        = $clog2(STAGES_P + 1)
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    exe_v_i,
   output logic                    ready_o,
   input  logic [1:0]              mode_i,
   input  logic [WIDTH_P-1:0]      operand1_i,
   input  logic [WIDTH_P-1:0]      operand2_i,
   input  logic [ROB_IDX_W-1:0]    rob_dest_i,
   input  logic [REG_IDX_W-1:0]    reg_dest_i,
   output logic [ROB_WB_WIDTH-1:0] mult_rob_o,
   output logic [REG_WB_WIDTH-1:0] mult_reg_o,
   input  logic                    yumi_i,
   input  logic                    mispredict_i,
   output logic [CNT_W-1:0]        inflight_o
);

   localparam int LAST = STAGES_P - 1;

   localparam logic [1:0] MODE_MUL    = 2'b00;
   localparam logic [1:0] MODE_MULH   = 2'b01;
   localparam logic [1:0] MODE_MULHSU = 2'b11;

   typedef struct packed {
      logic                 valid;
      logic [REG_IDX_W-1:0] dest;
      logic [WIDTH_P-1:0]   result;
      logic [FLAGS_W-1:0]   flags;
   } cdb_t;

   typedef struct packed {
      logic w_v;
      cdb_t cdb;
   } reg_wb_t;

   typedef struct packed {
      logic [ROB_IDX_W-1:0] rob_dest;
   } rob_wb_t;

   if (STAGES_P < 1 || STAGES_P > 8) begin : g_bad_stages
      $error("fu_mult_pipe: STAGES_P must be in 1..8");
   end

   logic [STAGES_P-1:0]  v_q, v_d;
   logic [ROB_IDX_W-1:0] rob_q [STAGES_P];
   logic [REG_IDX_W-1:0] reg_q [STAGES_P];
   logic [WIDTH_P-1:0]   res_q [STAGES_P];
   logic [CNT_W-1:0]     inflight_q, inflight_d;

   logic                 stall;
   logic                 accept;
   logic                 op1_signed, op2_signed;
   logic [2*WIDTH_P-1:0] op1_ext, op2_ext, product;
   logic [WIDTH_P-1:0]   res_s0;

   // Global stall: the whole pipe freezes while the arbiter refuses the head.
   assign stall   = v_q[LAST] & ~yumi_i;
   assign ready_o = ~stall;
   assign accept  = exe_v_i & ready_o & ~mispredict_i;

   // Extending both operands to 2*WIDTH_P lets a single unsigned multiplier
   // serve every mode: the low 2*WIDTH_P bits of the product are exact.
   assign op1_signed = (mode_i == MODE_MULH) | (mode_i == MODE_MULHSU);
   assign op2_signed = (mode_i == MODE_MULH);
   assign op1_ext    = {{WIDTH_P{op1_signed & operand1_i[WIDTH_P-1]}}, operand1_i};
   assign op2_ext    = {{WIDTH_P{op2_signed & operand2_i[WIDTH_P-1]}}, operand2_i};
   assign product    = op1_ext * op2_ext;
   assign res_s0     = (mode_i == MODE_MUL) ? product[WIDTH_P-1:0]
                                            : product[2*WIDTH_P-1:WIDTH_P];

   always_comb begin
      v_d = v_q;
      if (!stall) begin
         v_d[0] = accept;
         for (int i = 1; i < STAGES_P; i++) begin
            v_d[i] = v_q[i-1];
         end
      end
      // Flush wins over everything, including a held head entry.
      if (mispredict_i) begin
         v_d = '0;
      end
   end

   always_comb begin
      inflight_d = '0;
      for (int i = 0; i < STAGES_P; i++) begin
         inflight_d = inflight_d + CNT_W'(v_d[i]);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         v_q        <= '0;
         inflight_q <= '0;
         for (int i = 0; i < STAGES_P; i++) begin
            rob_q[i] <= '0;
            reg_q[i] <= '0;
            res_q[i] <= '0;
         end
      end else begin
         v_q        <= v_d;
         inflight_q <= inflight_d;
         // Payload moves with the pipe; a bubble still loads entry 0 because
         // only the valid bits carry meaning.
         if (!stall) begin
            rob_q[0] <= rob_dest_i;
            reg_q[0] <= reg_dest_i;
            res_q[0] <= res_s0;
            for (int i = 1; i < STAGES_P; i++) begin
               rob_q[i] <= rob_q[i-1];
               reg_q[i] <= reg_q[i-1];
               res_q[i] <= res_q[i-1];
            end
         end
      end
   end

   cdb_t    cdb;
   reg_wb_t reg_wb;
   rob_wb_t rob_wb;

   always_comb begin
      cdb.valid       = v_q[LAST];
      cdb.dest        = reg_q[LAST];
      cdb.result      = res_q[LAST];
      cdb.flags       = '0;
      reg_wb.cdb      = cdb;
      // Register file writes only when the arbiter actually takes the result.
      reg_wb.w_v      = v_q[LAST] & yumi_i;
      rob_wb.rob_dest = rob_q[LAST];
   end

   assign mult_reg_o = reg_wb;
   assign mult_rob_o = rob_wb;
   assign inflight_o = inflight_q;

   a_yumi_needs_valid : assert property (@(posedge clk_i) disable iff (reset_i)
                                         yumi_i |-> v_q[LAST])
      else $error("fu_mult_pipe: yumi_i asserted with no valid output");

endmodule

// File: tb/tb_fu_mult_pipe.sv
// tb/tb_fu_mult_pipe.sv - directed and scoreboard checks for fu_mult_pipe
module tb_fu_mult_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   int   n_chk = 0;
   int   n_err = 0;

   // Main unit: WIDTH 16, two stages
   logic        m_exe_v, m_ready, m_yumi, m_misp;
   logic [1:0]  m_mode;
   logic [15:0] m_a, m_b;
   logic [3:0]  m_rob, m_rob_o;
   logic [4:0]  m_reg;
   logic [24:0] m_reg_o;
   logic [1:0]  m_infl;
   logic        yumi_en;

   fu_mult_pipe #(.WIDTH_P(16), .STAGES_P(2), .ROB_ENTRY(16), .NUM_PHYS_REG(32)) u_dut (
      .clk_i(clk), .reset_i(rst), .exe_v_i(m_exe_v), .ready_o(m_ready), .mode_i(m_mode),
      .operand1_i(m_a), .operand2_i(m_b), .rob_dest_i(m_rob), .reg_dest_i(m_reg),
      .mult_rob_o(m_rob_o), .mult_reg_o(m_reg_o), .yumi_i(m_yumi),
      .mispredict_i(m_misp), .inflight_o(m_infl)
   );

   // Scoreboard units: index 0 has one stage, index 1 has four
   logic        r_exe_v [2];
   logic        r_yumi  [2];
   logic [1:0]  r_ready;
   logic [1:0]  r_mode  [2];
   logic [15:0] r_a     [2];
   logic [15:0] r_b     [2];
   logic [3:0]  r_rob   [2];
   logic [4:0]  r_reg   [2];
   logic [3:0]  r_rob_o [2];
   logic [24:0] r_reg_o [2];
   logic [2:0]  r_infl  [2];

   for (genvar g = 0; g < 2; g++) begin : g_rnd
      localparam int SG = (g == 0) ? 1 : 4;
      logic [$clog2(SG+1)-1:0] infl_w;
      fu_mult_pipe #(.WIDTH_P(16), .STAGES_P(SG), .ROB_ENTRY(16), .NUM_PHYS_REG(32)) u_dut (
         .clk_i(clk), .reset_i(rst), .exe_v_i(r_exe_v[g]), .ready_o(r_ready[g]),
         .mode_i(r_mode[g]), .operand1_i(r_a[g]), .operand2_i(r_b[g]),
         .rob_dest_i(r_rob[g]), .reg_dest_i(r_reg[g]), .mult_rob_o(r_rob_o[g]),
         .mult_reg_o(r_reg_o[g]), .yumi_i(r_yumi[g]), .mispredict_i(1'b0),
         .inflight_o(infl_w)
      );
      assign r_infl[g] = 3'(infl_w);
   end

   // reg_wb_t layout: [24] w_v, [23] valid, [22:18] dest, [17:2] result, [1:0] flags
   function automatic logic        f_wv  (input logic [24:0] r); return r[24];    endfunction
   function automatic logic        f_v   (input logic [24:0] r); return r[23];    endfunction
   function automatic logic [4:0]  f_dest(input logic [24:0] r); return r[22:18]; endfunction
   function automatic logic [15:0] f_res (input logic [24:0] r); return r[17:2];  endfunction
   function automatic logic [1:0]  f_flg (input logic [24:0] r); return r[1:0];   endfunction

   function automatic logic [15:0] mdl(input logic [1:0] md, input logic [15:0] a, input logic [15:0] b);
      logic signed [32:0] ea, eb;
      logic signed [65:0] p;
      ea = md[0] ? {{17{a[15]}}, a} : {17'b0, a};
      eb = (md == 2'b01) ? {{17{b[15]}}, b} : {17'b0, b};
      p  = ea * eb;
      return (md == 2'b00) ? p[15:0] : p[31:16];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      m_yumi = yumi_en & f_v(m_reg_o);
      #1;
   endtask

   task automatic issue(input logic [1:0] md, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] rob, input logic [4:0] rg);
      m_exe_v = 1'b1; m_mode = md; m_a = a; m_b = b; m_rob = rob; m_reg = rg;
   endtask

   logic [1:0]  t2_md  [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10};
   logic [15:0] t2_a   [5] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'hFFFF};
   logic [15:0] t2_b   [5] = '{16'h0002, 16'h0002, 16'h0002, 16'h0002, 16'hFFFF};
   logic [15:0] t2_exp [5] = '{16'h0000, 16'hFFFF, 16'h0001, 16'hFFFF, 16'hFFFE};

   logic [15:0] sb_res [2][16];
   logic [3:0]  sb_rob [2][16];
   int          sb_cyc [2][16];
   int          hd [2], tl [2];
   logic        acc [2], con [2], ov [2];
   int          rcyc, s, cnt, h;

   initial begin
      rst = 1'b1; m_exe_v = 0; m_mode = 0; m_a = 0; m_b = 0; m_rob = 0; m_reg = 0;
      m_yumi = 0; m_misp = 0; yumi_en = 0;
      for (int g = 0; g < 2; g++) begin
         r_exe_v[g] = 0; r_yumi[g] = 0; r_mode[g] = 0; r_a[g] = 0; r_b[g] = 0;
         r_rob[g] = 0; r_reg[g] = 0; hd[g] = 0; tl[g] = 0;
      end
      repeat (2) tick();
      rst = 1'b0;
      #1;
      check("rst_valid",    32'(f_v(m_reg_o)), 0);
      check("rst_result",   32'(f_res(m_reg_o)), 0);
      check("rst_rob",      32'(m_rob_o), 0);
      check("rst_inflight", 32'(m_infl), 0);
      check("rst_ready",    32'(m_ready), 1);
      check("rst_wv",       32'(f_wv(m_reg_o)), 0);

      // Basic latency: 3 x 5, rob 4 / reg 9
      yumi_en = 1;
      issue(2'b00, 16'h0003, 16'h0005, 4'd4, 5'd9);
      tick();
      m_exe_v = 0;
      check("t1_not_yet", 32'(f_v(m_reg_o)), 0);
      tick();
      check("t1_valid",  32'(f_v(m_reg_o)), 1);
      check("t1_result", 32'(f_res(m_reg_o)), 32'h000F);
      check("t1_rob",    32'(m_rob_o), 4);
      check("t1_dest",   32'(f_dest(m_reg_o)), 9);
      check("t1_wv",     32'(f_wv(m_reg_o)), 1);
      check("t1_flags",  32'(f_flg(m_reg_o)), 0);
      tick();
      check("t1_gone",   32'(f_v(m_reg_o)), 0);

      // Mode selection, back to back
      for (int i = 0; i < 6; i++) begin
         if (i < 5) issue(t2_md[i], t2_a[i], t2_b[i], 4'(i), 5'(i + 10));
         else m_exe_v = 0;
         tick();
         if (i >= 1) begin
            check("t2_valid",  32'(f_v(m_reg_o)), 1);
            check("t2_result", 32'(f_res(m_reg_o)), 32'(t2_exp[i-1]));
            check("t2_rob",    32'(m_rob_o), 32'(i - 1));
         end
      end
      tick();
      check("t2_gone", 32'(f_v(m_reg_o)), 0);

      // Stall with three back-to-back ops
      issue(2'b00, 16'd2, 16'd3, 4'd1, 5'd1);
      tick();
      issue(2'b00, 16'd4, 16'd5, 4'd2, 5'd2);
      tick();
      yumi_en = 0; m_yumi = 0;
      issue(2'b00, 16'd7, 16'd7, 4'd3, 5'd3);
      #1;
      check("st_ready0", 32'(m_ready), 0);
      tick();
      check("st_hold_res",  32'(f_res(m_reg_o)), 32'h0006);
      check("st_hold_rob",  32'(m_rob_o), 1);
      check("st_inflight",  32'(m_infl), 2);
      check("st_ready1",    32'(m_ready), 0);
      check("st_wv",        32'(f_wv(m_reg_o)), 0);
      tick();
      check("st_hold_res2", 32'(f_res(m_reg_o)), 32'h0006);
      check("st_hold_v2",   32'(f_v(m_reg_o)), 1);
      yumi_en = 1; m_yumi = 1;
      #1;
      check("st_rel_wv",    32'(f_wv(m_reg_o)), 1);
      check("st_rel_ready", 32'(m_ready), 1);
      tick();
      m_exe_v = 0;
      check("st_op2_res", 32'(f_res(m_reg_o)), 32'h0014);
      check("st_op2_rob", 32'(m_rob_o), 2);
      check("st_op2_wv",  32'(f_wv(m_reg_o)), 1);
      tick();
      check("st_op3_res", 32'(f_res(m_reg_o)), 32'h0031);
      check("st_op3_rob", 32'(m_rob_o), 3);
      tick();
      check("st_empty",    32'(f_v(m_reg_o)), 0);
      check("st_empty_if", 32'(m_infl), 0);

      // Flush while full and stalled, new issue in the same cycle
      yumi_en = 0;
      issue(2'b00, 16'd2, 16'd2, 4'd5, 5'd5);
      tick();
      issue(2'b00, 16'd3, 16'd3, 4'd6, 5'd6);
      tick();
      check("fl_pre_infl", 32'(m_infl), 2);
      issue(2'b00, 16'd9, 16'd9, 4'd7, 5'd7);
      m_misp = 1;
      tick();
      m_misp = 0; m_exe_v = 0;
      check("fl_valid", 32'(f_v(m_reg_o)), 0);
      check("fl_infl",  32'(m_infl), 0);
      check("fl_ready", 32'(m_ready), 1);
      check("fl_wv",    32'(f_wv(m_reg_o)), 0);
      tick();
      check("fl_valid2", 32'(f_v(m_reg_o)), 0);
      tick();
      check("fl_valid3", 32'(f_v(m_reg_o)), 0);

      // Flush together with a consume; issue in that cycle is dropped
      yumi_en = 1;
      issue(2'b00, 16'd2, 16'd5, 4'd8, 5'd8);
      tick();
      issue(2'b00, 16'd3, 16'd5, 4'd9, 5'd9);
      tick();
      issue(2'b00, 16'd4, 16'd5, 4'd10, 5'd10);
      m_misp = 1;
      #1;
      check("fy_wv",  32'(f_wv(m_reg_o)), 1);
      check("fy_res", 32'(f_res(m_reg_o)), 32'h000A);
      tick();
      m_misp = 0; m_exe_v = 0;
      check("fy_valid", 32'(f_v(m_reg_o)), 0);
      check("fy_infl",  32'(m_infl), 0);
      tick();
      check("fy_valid2", 32'(f_v(m_reg_o)), 0);
      tick();
      check("fy_dropped", 32'(f_v(m_reg_o)), 0);

      // Reset with two ops in flight
      yumi_en = 0;
      issue(2'b00, 16'd5, 16'd5, 4'd11, 5'd11);
      tick();
      issue(2'b00, 16'd6, 16'd6, 4'd12, 5'd12);
      tick();
      check("rm_pre_infl", 32'(m_infl), 2);
      m_exe_v = 0;
      rst = 1;
      tick();
      rst = 0;
      #1;
      check("rm_valid", 32'(f_v(m_reg_o)), 0);
      check("rm_infl",  32'(m_infl), 0);
      check("rm_ready", 32'(m_ready), 1);
      check("rm_wv",    32'(f_wv(m_reg_o)), 0);
      tick();
      check("rm_valid2", 32'(f_v(m_reg_o)), 0);

      // Scoreboard runs on the 1- and 4-stage units:
      // phase 0 no stall (exact latency), phase 1 random yumi, phase 2 drain
      rcyc = 0;
      for (int ph = 0; ph < 3; ph++) begin
         for (int c = 0; c < ((ph == 2) ? 30 : 200); c++) begin
            for (int g = 0; g < 2; g++) begin
               s     = (g == 0) ? 1 : 4;
               cnt   = tl[g] - hd[g];
               h     = hd[g] & 15;
               ov[g] = f_v(r_reg_o[g]);
               check("rnd_inflight", 32'(r_infl[g]), 32'(cnt));
               if (ph == 0)
                  check("rnd_valid_nostall", 32'(ov[g]), 32'(cnt > 0 && (rcyc - sb_cyc[g][h]) >= s));
               else if (cnt == 0 || (rcyc - sb_cyc[g][h]) < s)
                  check("rnd_valid_early", 32'(ov[g]), 0);
               if (ov[g] && cnt > 0) begin
                  check("rnd_result", 32'(f_res(r_reg_o[g])), 32'(sb_res[g][h]));
                  check("rnd_rob",    32'(r_rob_o[g]), 32'(sb_rob[g][h]));
               end
               r_yumi[g]  = ov[g] & ((ph != 1) | ($urandom_range(0, 1) == 1));
               r_exe_v[g] = (ph != 2) && ($urandom_range(0, 9) < 7);
               r_mode[g]  = 2'($urandom_range(0, 3));
               r_a[g]     = 16'($urandom);
               r_b[g]     = 16'($urandom);
               r_rob[g]   = 4'(tl[g]);
               r_reg[g]   = 5'($urandom);
            end
            #1;
            for (int g = 0; g < 2; g++) begin
               check("rnd_ready", 32'(r_ready[g]), 32'(!(ov[g] && !r_yumi[g])));
               acc[g] = r_exe_v[g] & r_ready[g];
               con[g] = r_yumi[g];
            end
            @(posedge clk);
            #1;
            for (int g = 0; g < 2; g++) begin
               if (con[g]) hd[g]++;
               if (acc[g]) begin
                  sb_res[g][tl[g] & 15] = mdl(r_mode[g], r_a[g], r_b[g]);
                  sb_rob[g][tl[g] & 15] = r_rob[g];
                  sb_cyc[g][tl[g] & 15] = rcyc;
                  tl[g]++;
               end
            end
            rcyc++;
         end
      end
      for (int g = 0; g < 2; g++) begin
         check("rnd_drained", 32'(tl[g] - hd[g]), 0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/fu_mult_pipe.md
Name: fu_mult_pipe

Overview:
- Parametrised, pipelined integer multiply functional unit in the execute stage; next generation of the fixed two-stage multiplier.
- Adds configurable depth, low/high-half and signedness modes, and a valid/ready/yumi handshake so the CDB arbiter can back-pressure the unit.
- Retains the single-cycle mispredict flush.
- Results leave as rob_wb_t / reg_wb_t packed structs, like the other FUs.

Parameters:
- WIDTH_P, default WORD_SIZE_P: operand and result width.
- STAGES_P, default 2: pipeline depth and latency. Legal range is 1..8; an elaboration-time assertion rejects other values.
- ROB_IDX_W, default $clog2(ROB_ENTRY): ROB tag width.
- REG_IDX_W, default $clog2(NUM_PHYS_REG): physical register tag width.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- exe_v_i  in  1  issue valid
- ready_o  out  1  unit can accept an issue this cycle
- mode_i  in  2  00 MUL (low half), 01 MULH (s×s high), 10 MULHU (u×u high), 11 MULHSU (s×u high)
- operand1_i  in  WIDTH_P  multiplicand
- operand2_i  in  WIDTH_P  multiplier
- rob_dest_i  in  ROB_IDX_W  ROB tag
- reg_dest_i  in  REG_IDX_W  physical destination tag
- mult_rob_o  out  ROB_WB_WIDTH  rob_wb_t writeback
- mult_reg_o  out  REG_WB_WIDTH  reg_wb_t writeback
- yumi_i  in  1  CDB arbiter consumed the current output
- mispredict_i  in  1  flush all in-flight ops
- inflight_o  out  $clog2(STAGES_P+1)  number of valid pipeline entries

Behaviour:
- Issue acceptance: an issue is accepted when exe_v_i & ready_o & ~mispredict_i.
- Product formation:
  - The full 2·WIDTH_P product is formed at stage 0 from operands extended per mode_i. Extension is sign or zero, each operand to 2·WIDTH_P bits.
  - MUL selects product[WIDTH_P-1:0]; all other modes select product[2·WIDTH_P-1:WIDTH_P].
  - Selection happens at stage 0; only WIDTH_P result bits are carried down the pipe. The low half is mode-independent.
- Pipeline: STAGES_P entries, each holding {v, rob_dest, reg_dest, result}. The output is driven from the last entry.
- Latency: an issue accepted on edge N appears at the output from edge N+STAGES_P when there is no stall.
- Stall:
  - stall = v_last & ~yumi_i.
  - On a stall the whole pipe holds (global stall, no bubble collapsing).
  - ready_o = ~stall, which is combinational in yumi_i.
  - When not stalled, every entry shifts by one, and entry 0 loads the accepted issue or a bubble.
- Output fields:
  - mult_rob_o.rob_dest = last entry rob_dest.
  - cdb.valid = v_last; cdb.dest = last reg_dest; cdb.result = last result; cdb.flags = '0.
  - mult_reg_o.cdb equals the same cdb; mult_reg_o.w_v = v_last & yumi_i, so the register file writes only on consume.
- Output stability: while stalled, all output fields hold stable.
- Flush:
  - mispredict_i on edge N clears every v bit, including the last entry. This applies whether or not the pipe is stalled and whether or not yumi_i is asserted.
  - Any issue presented in the same cycle is dropped.
  - The payload registers may keep stale data; only valid bits matter.
- yumi_i rules:
  - yumi_i while v_last = 0 is illegal (assertion).
  - yumi_i and mispredict_i together: the consume is honoured for w_v in that cycle; the pipe is empty afterwards.
- inflight_o: popcount of the v bits, registered alongside them. It saturates naturally at STAGES_P and reads 0 after a flush.
- Reset: all v bits, payloads and inflight_o are 0. Outputs read valid 0 and data 0. ready_o is 1 from the first cycle after reset.
- Reset mid-operation: in-flight ops are discarded with no writeback.
- Back-to-back issue: with yumi_i held high, one result per cycle and full throughput.

Test Plan:
- WIDTH_P=16, STAGES_P=2, yumi_i=1: issue 0x0003×0x0005 MUL, tag rob 4 / reg 9. Required: valid two cycles later with result 0x000F, rob_dest 4, dest 9, w_v=1.
- Operands 0x8000×0x0002, one issue per mode:
  - MUL → 0x0000
  - MULH → 0xFFFF
  - MULHU → 0x0001
  - MULHSU → 0xFFFF
  - Also 0xFFFF×0xFFFF MULHU → 0xFFFE.
- Stall:
  - Issue 3 back-to-back ops with yumi_i=0 once the first arrives. Required: ready_o=0, the output holds op 1, inflight_o=2, w_v=0.
  - Raise yumi_i for 3 cycles. Required: ops 1, 2, 3 emerge in order, one per cycle.
- Flush with the pipe full and stalled, and exe_v_i=1 in the same cycle. Required: next cycle valid=0, inflight_o=0, ready_o=1; no writeback of any flushed op or of the new issue.
- STAGES_P=1 and STAGES_P=4 builds: random ops with random yumi_i. A scoreboard checks in-order results, latency exactly STAGES_P with no stall, and ordering preserved under stall.
- Reset asserted with 2 ops in flight. Required: after reset, no valid output, inflight_o=0, ready_o=1.
